// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-register scoreboard for the 32x32 register file.
// Optional build macro WB_BYPASS_EN masks busy for a register whose write is accepted this cycle.
module regfile_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_reg,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_reg,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic              rs_busy,
    output logic              rt_busy,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_reg,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W:0]   pending_cnt
);

    localparam int NREG = 2 ** ADDR_W;
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic {
        PRI_MEM = 1'b0,
        PRI_ALU = 1'b1
    } arb_state_e;

    arb_state_e        state_q, state_d;
    logic [3:0]        starve_q, starve_d;
    logic [NREG-1:0]   pending_q, pending_d;
    logic [ADDR_W:0]   pending_cnt_q, pending_cnt_d;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_reg_q;
    logic [DATA_W-1:0] wr_data_q;

    logic              accept;
    logic [ADDR_W-1:0] acc_reg;
    logic [DATA_W-1:0] acc_data;

    // State register (arbiter state and starvation counter)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= PRI_MEM;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        starve_d = '0;
        if (alu_valid && !alu_ready)
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        case (state_q)
            PRI_MEM: if (starve_d == STARVE_LIM) state_d = PRI_ALU;
            PRI_ALU: if (alu_ready)              state_d = PRI_MEM;
            default: state_d = PRI_MEM;
        endcase
    end

    // Output logic: grants are held off entirely while reset is asserted
    always_comb begin
        alu_ready = 1'b0;
        mem_ready = 1'b0;
        if (rst_n) begin
            if (state_q == PRI_ALU) begin
                alu_ready = alu_valid;
                mem_ready = mem_valid && !alu_valid;
            end else begin
                mem_ready = mem_valid;
                alu_ready = alu_valid && !mem_valid;
            end
        end
    end

    assign accept   = alu_ready || mem_ready;
    assign acc_reg  = alu_ready ? alu_reg  : mem_reg;
    assign acc_data = alu_ready ? alu_data : mem_data;

    // Set is applied after clear so a newer producer keeps the bit pending
    always_comb begin
        pending_d = pending_q;
        if (accept)
            pending_d[acc_reg] = 1'b0;
        if (issue_valid)
            pending_d[issue_reg] = 1'b1;
        pending_d[0] = 1'b0;
        pending_cnt_d = '0;
        for (int i = 1; i < NREG; i++)
            pending_cnt_d = pending_cnt_d + (ADDR_W+1)'(pending_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q     <= '0;
            pending_cnt_q <= '0;
            wr_en_q       <= 1'b0;
            wr_reg_q      <= '0;
            wr_data_q     <= '0;
        end else begin
            pending_q     <= pending_d;
            pending_cnt_q <= pending_cnt_d;
            wr_en_q       <= accept && (acc_reg != '0);
            if (accept) begin
                wr_reg_q  <= acc_reg;
                wr_data_q <= acc_data;
            end
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_reg      = wr_reg_q;
    assign wr_data     = wr_data_q;
    assign pending_cnt = pending_cnt_q;

`ifdef WB_BYPASS_EN
    assign rs_busy = pending_q[rs_addr] && !(accept && (acc_reg == rs_addr));
    assign rt_busy = pending_q[rt_addr] && !(accept && (acc_reg == rt_addr));
`else
    assign rs_busy = pending_q[rs_addr];
    assign rt_busy = pending_q[rt_addr];
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter (STARVE_MAX = 3).
module tb_regfile_wb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              alu_valid, mem_valid, issue_valid;
    logic              alu_ready, mem_ready;
    logic [ADDR_W-1:0] alu_reg, mem_reg, issue_reg, rs_addr, rt_addr;
    logic [DATA_W-1:0] alu_data, mem_data;
    logic              rs_busy, rt_busy, wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W:0]   pending_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
        .issue_valid(issue_valid), .issue_reg(issue_reg),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_busy(rs_busy), .rt_busy(rt_busy),
        .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pending_cnt(pending_cnt)
    );

    // Inputs change 1 time unit after the rising edge; checks happen a further unit later.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        alu_valid = 0; mem_valid = 0; issue_valid = 0;
        alu_reg = 0; mem_reg = 0; issue_reg = 0; rs_addr = 0; rt_addr = 0;
        alu_data = 0; mem_data = 0;
        #2;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL rst_pcnt: got %0d want 0", pending_cnt); end
        mem_valid = 1; alu_valid = 1; #1;
        checks++; if (mem_ready !== 1'b0 || alu_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got mem=%b alu=%b want 0/0", mem_ready, alu_ready); end
        mem_valid = 0; alu_valid = 0;
        tick; tick;
        rst_n = 1'b1;
        tick;
        issue_valid = 1; issue_reg = 10;
        mem_valid = 1; mem_reg = 5; mem_data = 32'hAAAA_0005; #1;
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL rst_pre_ready: got %b want 1", mem_ready); end
        tick;
        issue_valid = 0; #1;
        checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd5) begin failures++; $display("FAIL rst_pre_wr: got en=%b reg=%0d want 1/5", wr_en, wr_reg); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL rst_pre_pcnt: got %0d want 1", pending_cnt); end
        // second request is in flight when reset hits
        rst_n = 1'b0; #1;
        checks++; if (wr_en !== 1'b0 || wr_reg !== 5'd0 || wr_data !== 32'd0) begin failures++; $display("FAIL rst_mid_wr: got en=%b reg=%0d data=%h want 0/0/0", wr_en, wr_reg, wr_data); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL rst_mid_pcnt: got %0d want 0", pending_cnt); end
        checks++; if (mem_ready !== 1'b0) begin failures++; $display("FAIL rst_mid_ready: got %b want 0", mem_ready); end
        mem_valid = 0;
        tick;
        rst_n = 1'b1;
        tick;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_post_wr1: got %b want 0", wr_en); end
        tick;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL rst_post_wr2: got %b want 0", wr_en); end
        $display("reset: done");
    endtask

    task automatic test_single_write;
        tick;
        issue_valid = 1; issue_reg = 7; rt_addr = 7; #1;
        checks++; if (rt_busy !== 1'b0) begin failures++; $display("FAIL sw_busy_pre: got %b want 0", rt_busy); end
        tick;
        issue_valid = 0; #1;
        checks++; if (rt_busy !== 1'b1) begin failures++; $display("FAIL sw_busy_wait: got %b want 1", rt_busy); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL sw_pcnt1: got %0d want 1", pending_cnt); end
        tick;
        alu_valid = 1; alu_reg = 7; alu_data = 32'h0000_1234; #1;
        checks++; if (alu_ready !== 1'b1 || mem_ready !== 1'b0) begin failures++; $display("FAIL sw_ready: got alu=%b mem=%b want 1/0", alu_ready, mem_ready); end
        checks++; if (rt_busy !== !BYP) begin failures++; $display("FAIL sw_busy_acc: got %b want %b", rt_busy, !BYP); end
        tick;
        alu_valid = 0; #1;
        checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd7 || wr_data !== 32'h0000_1234) begin failures++; $display("FAIL sw_wr: got en=%b reg=%0d data=%h want 1/7/00001234", wr_en, wr_reg, wr_data); end
        checks++; if (pending_cnt !== 6'd0) begin failures++; $display("FAIL sw_pcnt0: got %0d want 0", pending_cnt); end
        checks++; if (rt_busy !== 1'b0) begin failures++; $display("FAIL sw_busy_post: got %b want 0", rt_busy); end
        tick;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL sw_wr_once: got %b want 0", wr_en); end
        $display("single write: reg=%0d data=%h", 7, 32'h1234);
    endtask

    task automatic test_contention;
        logic [ADDR_W-1:0] exp_reg;
        bit                exp_alu;
        alu_valid = 1; alu_reg = 5'd1; alu_data = 32'hA1A1_0001;
        mem_valid = 1; mem_reg = 5'd2; mem_data = 32'hB2B2_0002;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_alu = (i % 4) == 3;
            exp_reg = exp_alu ? 5'd1 : 5'd2;
            checks++; if (alu_ready !== exp_alu || mem_ready !== !exp_alu) begin failures++; $display("FAIL cont_grant%0d: got alu=%b mem=%b want %b/%b", i, alu_ready, mem_ready, exp_alu, !exp_alu); end
            tick;
            checks++; if (wr_en !== 1'b1 || wr_reg !== exp_reg) begin failures++; $display("FAIL cont_wr%0d: got en=%b reg=%0d want 1/%0d", i, wr_en, wr_reg, exp_reg); end
            $display("contention grant %0d: %s", i, exp_alu ? "alu" : "mem");
        end
        alu_valid = 0; mem_valid = 0;
        tick;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL cont_idle: got %b want 0", wr_en); end
    endtask

    task automatic test_reg0;
        mem_valid = 1; mem_reg = 0; mem_data = 32'hFFFF_FFFF; rs_addr = 0;
        issue_valid = 1; issue_reg = 0; #1;
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL r0_ready: got %b want 1", mem_ready); end
        checks++; if (rs_busy !== 1'b0) begin failures++; $display("FAIL r0_busy_acc: got %b want 0", rs_busy); end
        tick;
        mem_valid = 0; issue_valid = 0; #1;
        checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL r0_wr_en: got %b want 0", wr_en); end
        checks++; if (rs_busy !== 1'b0 || pending_cnt !== 6'd0) begin failures++; $display("FAIL r0_pend: got busy=%b cnt=%0d want 0/0", rs_busy, pending_cnt); end
        $display("reg0 write: accepted, no write");
    endtask

    task automatic test_collision;
        tick;
        issue_valid = 1; issue_reg = 3;
        tick;
        issue_valid = 1; issue_reg = 3; rs_addr = 3;
        alu_valid = 1; alu_reg = 3; alu_data = 32'h0000_0033; #1;
        checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL col_ready: got %b want 1", alu_ready); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL col_pcnt_pre: got %0d want 1", pending_cnt); end
        tick;
        issue_valid = 0; alu_valid = 0; #1;
        checks++; if (rs_busy !== 1'b1) begin failures++; $display("FAIL col_busy: got %b want 1", rs_busy); end
        checks++; if (pending_cnt !== 6'd1) begin failures++; $display("FAIL col_pcnt: got %0d want 1", pending_cnt); end
        checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd3 || wr_data !== 32'h33) begin failures++; $display("FAIL col_wr: got en=%b reg=%0d data=%h want 1/3/00000033", wr_en, wr_reg, wr_data); end
        alu_valid = 1;
        tick;
        alu_valid = 0; #1;
        checks++; if (pending_cnt !== 6'd0 || rs_busy !== 1'b0) begin failures++; $display("FAIL col_clear: got cnt=%0d busy=%b want 0/0", pending_cnt, rs_busy); end
        $display("collision: reg 3 stays pending");
    endtask

    task automatic test_bypass;
        tick;
        issue_valid = 1; issue_reg = 9; rs_addr = 9;
        tick;
        issue_valid = 0; #1;
        checks++; if (rs_busy !== 1'b1) begin failures++; $display("FAIL byp_busy_pre: got %b want 1", rs_busy); end
        mem_valid = 1; mem_reg = 9; mem_data = 32'h0000_0099; #1;
        checks++; if (mem_ready !== 1'b1) begin failures++; $display("FAIL byp_ready: got %b want 1", mem_ready); end
        checks++; if (rs_busy !== !BYP) begin failures++; $display("FAIL byp_busy_acc: got %b want %b", rs_busy, !BYP); end
        tick;
        mem_valid = 0; #1;
        checks++; if (rs_busy !== 1'b0 || pending_cnt !== 6'd0) begin failures++; $display("FAIL byp_post: got busy=%b cnt=%0d want 0/0", rs_busy, pending_cnt); end
        checks++; if (wr_en !== 1'b1 || wr_reg !== 5'd9 || wr_data !== 32'h99) begin failures++; $display("FAIL byp_wr: got en=%b reg=%0d data=%h want 1/9/00000099", wr_en, wr_reg, wr_data); end
        $display("bypass: build bypass=%0d", BYP);
    endtask

    initial begin
        test_reset;
        test_single_write;
        test_contention;
        test_reg0;
        test_collision;
        test_bypass;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
